// File: rtl/pc_sequencer_if.sv
// Writeback-side bus of the PC sequencer: retire strobe, instruction and flags
// in; fetch address and transfer pulse out.
interface pc_sequencer_if #(
  parameter int PC_W = 16
);
  logic            wb_en;
  logic [31:0]     crnt_instrn;
  logic            zro_flag;
  logic            carry_flag;
  logic            neg_flag;
  logic            ovf_flag;
  logic [PC_W-1:0] pc;
  logic            branch_taken;

  modport master (
    output wb_en, crnt_instrn, zro_flag, carry_flag, neg_flag, ovf_flag,
    input  pc, branch_taken
  );

  modport slave (
    input  wb_en, crnt_instrn, zro_flag, carry_flag, neg_flag, ovf_flag,
    output pc, branch_taken
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with conditional jump/call/return and a hardware return
// stack; resolves one retired instruction per writeback strobe.
module pc_sequencer #(
  parameter int          PC_W        = 16,
  parameter int          STACK_DEPTH = 8,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  localparam int         LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_sequencer_if.slave    bus,
  input  logic             clr_err,
  output logic [LVL_W-1:0] stk_level,
  output logic             stk_ovf,
  output logic             stk_unf
);
  localparam int              IDX_W  = $clog2(STACK_DEPTH);
  localparam logic [PC_W-1:0] RST_PC = RESET_PC[PC_W-1:0];

  function automatic logic cond_take(input logic [7:0] sel, input logic inv,
                                     input logic zf, input logic cf,
                                     input logic nf, input logic vf);
    logic t;
    case (sel)
      8'h00:   t = nf ^ inv;
      8'h01:   t = zf ^ inv;
      8'h02:   t = cf ^ inv;
      8'h03:   t = vf ^ inv;
      8'h3F:   t = ~inv;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [PC_W-1:0]  pc_r;
  logic [LVL_W-1:0] stk_level_r;
  logic             branch_taken_r;
  logic             stk_ovf_r;
  logic             stk_unf_r;
  logic [PC_W-1:0]  stack_r [0:STACK_DEPTH-1];

  logic             is_flow_s, is_ret_s, is_call_s, is_jmp_s, take_s;
  logic             stk_empty_s, stk_full_s;
  logic [PC_W-1:0]  pc_inc_s, target_s, nxt_pc_s;
  logic [LVL_W-1:0] lvl_dec_s, nxt_lvl_s;
  logic [IDX_W-1:0] push_idx_s, pop_idx_s;
  logic             nxt_taken_s, push_s, set_ovf_s, set_unf_s;
  logic             unused_instr_s;

  assign is_flow_s   = (bus.crnt_instrn[31:30] == 2'b00);
  assign is_ret_s    = is_flow_s & bus.crnt_instrn[27];
  assign is_call_s   = is_flow_s & bus.crnt_instrn[28];
  assign is_jmp_s    = is_flow_s & bus.crnt_instrn[29];
  assign take_s      = cond_take(bus.crnt_instrn[23:16], bus.crnt_instrn[25],
                                 bus.zro_flag, bus.carry_flag,
                                 bus.neg_flag, bus.ovf_flag);
  assign target_s    = bus.crnt_instrn[PC_W-1:0];
  assign pc_inc_s    = pc_r + PC_W'(1);
  assign stk_empty_s = (stk_level_r == {LVL_W{1'b0}});
  assign stk_full_s  = (stk_level_r == LVL_W'(STACK_DEPTH));
  assign lvl_dec_s   = stk_level_r - LVL_W'(1);
  assign push_idx_s  = stk_level_r[IDX_W-1:0];
  assign pop_idx_s   = lvl_dec_s[IDX_W-1:0];
  // Only some instruction bits steer the sequencer; fold the rest away.
  assign unused_instr_s = ^bus.crnt_instrn;

  // Next-state resolution: return beats call beats jump beats sequential.
  always_comb begin
    nxt_pc_s    = pc_r;
    nxt_lvl_s   = stk_level_r;
    nxt_taken_s = 1'b0;
    push_s      = 1'b0;
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    if (bus.wb_en) begin
      if (is_ret_s) begin
        if (!stk_empty_s) begin
          nxt_pc_s    = stack_r[pop_idx_s];
          nxt_lvl_s   = lvl_dec_s;
          nxt_taken_s = 1'b1;
        end else begin
          set_unf_s = 1'b1;
          nxt_pc_s  = pc_inc_s;
        end
      end else if (is_call_s && take_s) begin
        if (!stk_full_s) begin
          push_s      = 1'b1;
          nxt_pc_s    = target_s;
          nxt_lvl_s   = stk_level_r + LVL_W'(1);
          nxt_taken_s = 1'b1;
        end else begin
          set_ovf_s = 1'b1;
          nxt_pc_s  = pc_inc_s;
        end
      end else if (is_jmp_s && take_s) begin
        nxt_pc_s    = target_s;
        nxt_taken_s = 1'b1;
      end else begin
        nxt_pc_s = pc_inc_s;
      end
    end else begin
      nxt_pc_s = pc_r;
    end
  end

  // Control state; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r           <= RST_PC;
      stk_level_r    <= {LVL_W{1'b0}};
      branch_taken_r <= 1'b0;
      stk_ovf_r      <= 1'b0;
      stk_unf_r      <= 1'b0;
    end else begin
      pc_r           <= nxt_pc_s;
      stk_level_r    <= nxt_lvl_s;
      branch_taken_r <= nxt_taken_s;
      stk_ovf_r      <= set_ovf_s | (stk_ovf_r & ~clr_err);
      stk_unf_r      <= set_unf_s | (stk_unf_r & ~clr_err);
    end
  end

  // Return-address storage; popped entries are left as they are.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[push_idx_s] <= pc_inc_s;
    end
  end

  assign bus.pc           = pc_r;
  assign bus.branch_taken = branch_taken_r;
  assign stk_level        = stk_level_r;
  assign stk_ovf          = stk_ovf_r;
  assign stk_unf          = stk_unf_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: a 16-bit, 2-deep instance (RESET_PC=0x10) for branching and
// stack checks, and a 4-bit instance (RESET_PC=0x5) for wrap and reset checks.
module tb_pc_sequencer;
  localparam logic [31:0] NOP  = 32'hC000_0000;
  localparam logic [31:0] RET  = 32'h0800_0000;

  logic       clk = 1'b0;
  logic       rst_a_n = 1'b0;
  logic       rst_b_n = 1'b0;
  logic       clr_a = 1'b0;
  logic       clr_b = 1'b0;
  logic [1:0] lvl_a, lvl_b;
  logic       ovf_a, unf_a, ovf_b, unf_b;
  int         checks = 0;
  int         fails = 0;

  pc_sequencer_if #(.PC_W(16)) ifa ();
  pc_sequencer_if #(.PC_W(4))  ifb ();

  pc_sequencer #(.PC_W(16), .STACK_DEPTH(2), .RESET_PC(16'h0010)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(ifa), .clr_err(clr_a),
    .stk_level(lvl_a), .stk_ovf(ovf_a), .stk_unf(unf_a)
  );

  pc_sequencer #(.PC_W(4), .STACK_DEPTH(2), .RESET_PC(16'h0005)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(ifb), .clr_err(clr_b),
    .stk_level(lvl_b), .stk_ovf(ovf_b), .stk_unf(unf_b)
  );

  always #5 clk = ~clk;

  // flg = {ovf, neg, carry, zro}
  task automatic wb_a(input logic [31:0] ins, input logic [3:0] flg, input logic clr);
    ifa.wb_en = 1'b1; ifa.crnt_instrn = ins; clr_a = clr;
    {ifa.ovf_flag, ifa.neg_flag, ifa.carry_flag, ifa.zro_flag} = flg;
    @(posedge clk); #1;
    ifa.wb_en = 1'b0; ifa.crnt_instrn = 32'h0000_0000; clr_a = 1'b0;
    {ifa.ovf_flag, ifa.neg_flag, ifa.carry_flag, ifa.zro_flag} = 4'b0000;
  endtask

  task automatic wb_b(input logic [31:0] ins);
    ifb.wb_en = 1'b1; ifb.crnt_instrn = ins;
    @(posedge clk); #1;
    ifb.wb_en = 1'b0; ifb.crnt_instrn = 32'h0000_0000;
  endtask

  task automatic chk_a(input string nm, input logic [15:0] epc, input logic ebt,
                       input logic [1:0] elvl);
    checks++;
    if (ifa.pc !== epc || ifa.branch_taken !== ebt || lvl_a !== elvl) begin
      fails++;
      $display("FAIL %s got pc=%h bt=%b lvl=%0d exp pc=%h bt=%b lvl=%0d",
               nm, ifa.pc, ifa.branch_taken, lvl_a, epc, ebt, elvl);
    end
  endtask

  task automatic test_reset();
    ifa.wb_en = 1'b0; ifa.crnt_instrn = 32'h0000_0000;
    {ifa.ovf_flag, ifa.neg_flag, ifa.carry_flag, ifa.zro_flag} = 4'b0000;
    ifb.wb_en = 1'b0; ifb.crnt_instrn = 32'h0000_0000;
    {ifb.ovf_flag, ifb.neg_flag, ifb.carry_flag, ifb.zro_flag} = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;
    chk_a("reset_a", 16'h0010, 1'b0, 2'd0);
    checks++;
    if (ovf_a !== 1'b0 || unf_a !== 1'b0) begin
      fails++; $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", ovf_a, unf_a);
    end
    checks++;
    if (ifb.pc !== 4'h5 || lvl_b !== 2'd0 || ifb.branch_taken !== 1'b0) begin
      fails++; $display("FAIL reset_b got pc=%h lvl=%0d bt=%b exp pc=5 lvl=0 bt=0",
                        ifb.pc, lvl_b, ifb.branch_taken);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      wb_a(NOP, 4'b1111, 1'b0);
      chk_a("seq_run", 16'h0010 + 16'(i), 1'b0, 2'd0);
    end
  endtask

  task automatic test_cond_jump();
    wb_a(32'h203F_0020, 4'b0000, 1'b0); chk_a("jmp_always", 16'h0020, 1'b1, 2'd0);
    @(posedge clk); #1;                chk_a("idle_hold", 16'h0020, 1'b0, 2'd0);
    wb_a(32'h2001_0040, 4'b0001, 1'b0); chk_a("jmp_zero", 16'h0040, 1'b1, 2'd0);
    wb_a(32'h203F_0020, 4'b0000, 1'b0); chk_a("jmp_back", 16'h0020, 1'b1, 2'd0);
    wb_a(32'h2201_0040, 4'b0001, 1'b0); chk_a("jmp_nz_untaken", 16'h0021, 1'b0, 2'd0);
    wb_a(32'h2201_0040, 4'b0000, 1'b0); chk_a("jmp_nz_taken", 16'h0040, 1'b1, 2'd0);
    wb_a(32'h2005_0060, 4'b1111, 1'b0); chk_a("jmp_never_sel", 16'h0041, 1'b0, 2'd0);
    wb_a(32'h223F_0060, 4'b0000, 1'b0); chk_a("jmp_always_inv", 16'h0042, 1'b0, 2'd0);
    wb_a(32'h2000_0066, 4'b0011, 1'b0); chk_a("jmp_neg_clear", 16'h0043, 1'b0, 2'd0);
    wb_a(32'h2002_0077, 4'b0010, 1'b0); chk_a("jmp_carry", 16'h0077, 1'b1, 2'd0);
    wb_a(32'h2003_0011, 4'b1000, 1'b0); chk_a("jmp_ovf", 16'h0011, 1'b1, 2'd0);
  endtask

  task automatic test_call_return();
    wb_a(32'h203F_0030, 4'b0000, 1'b0); chk_a("cr_setup", 16'h0030, 1'b1, 2'd0);
    wb_a(32'h103F_0080, 4'b0000, 1'b0); chk_a("call_always", 16'h0080, 1'b1, 2'd1);
    wb_a(RET, 4'b0000, 1'b0);           chk_a("ret_b2b", 16'h0031, 1'b1, 2'd0);
    wb_a(32'h1001_0090, 4'b0000, 1'b0); chk_a("call_untaken", 16'h0032, 1'b0, 2'd0);
  endtask

  task automatic test_overflow();
    wb_a(32'h203F_0050, 4'b0000, 1'b0); chk_a("ovf_setup", 16'h0050, 1'b1, 2'd0);
    wb_a(32'h103F_0060, 4'b0000, 1'b0); chk_a("ovf_call1", 16'h0060, 1'b1, 2'd1);
    wb_a(32'h303F_0070, 4'b0000, 1'b0); chk_a("ovf_call2", 16'h0070, 1'b1, 2'd2);
    wb_a(32'h103F_0090, 4'b0000, 1'b0); chk_a("ovf_call3", 16'h0071, 1'b0, 2'd2);
    checks++;
    if (ovf_a !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", ovf_a); end
    wb_a(RET, 4'b0000, 1'b0);           chk_a("ovf_ret1", 16'h0061, 1'b1, 2'd1);
    wb_a(RET, 4'b0000, 1'b0);           chk_a("ovf_ret2", 16'h0051, 1'b1, 2'd0);
    checks++;
    if (ovf_a !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", ovf_a); end
    clr_a = 1'b1; @(posedge clk); #1; clr_a = 1'b0;
    checks++;
    if (ovf_a !== 1'b0) begin fails++; $display("FAIL ovf_clr got=%b exp=0", ovf_a); end
  endtask

  task automatic test_underflow();
    wb_a(RET, 4'b0000, 1'b0);           chk_a("unf_ret", 16'h0052, 1'b0, 2'd0);
    checks++;
    if (unf_a !== 1'b1) begin fails++; $display("FAIL unf_set got=%b exp=1", unf_a); end
    clr_a = 1'b1; @(posedge clk); #1; clr_a = 1'b0;
    checks++;
    if (unf_a !== 1'b0 || ifa.pc !== 16'h0052) begin
      fails++; $display("FAIL unf_clr got unf=%b pc=%h exp unf=0 pc=0052", unf_a, ifa.pc);
    end
    wb_a(RET, 4'b0000, 1'b1);           chk_a("unf_clr_ret", 16'h0053, 1'b0, 2'd0);
    checks++;
    if (unf_a !== 1'b1 || ovf_a !== 1'b0) begin
      fails++; $display("FAIL unf_err_wins got unf=%b ovf=%b exp unf=1 ovf=0", unf_a, ovf_a);
    end
  endtask

  task automatic test_wrap_and_reset();
    wb_b(32'h203F_000F);
    checks++;
    if (ifb.pc !== 4'hF) begin fails++; $display("FAIL wrap_setup got=%h exp=f", ifb.pc); end
    wb_b(NOP);
    checks++;
    if (ifb.pc !== 4'h0 || ifb.branch_taken !== 1'b0) begin
      fails++; $display("FAIL wrap_seq got pc=%h bt=%b exp pc=0 bt=0", ifb.pc, ifb.branch_taken);
    end
    wb_b(32'h203F_000F);
    wb_b(32'h103F_0009);
    checks++;
    if (ifb.pc !== 4'h9 || lvl_b !== 2'd1) begin
      fails++; $display("FAIL wrap_call got pc=%h lvl=%0d exp pc=9 lvl=1", ifb.pc, lvl_b);
    end
    wb_b(RET);
    checks++;
    if (ifb.pc !== 4'h0 || lvl_b !== 2'd0 || ifb.branch_taken !== 1'b1) begin
      fails++; $display("FAIL wrap_ret got pc=%h lvl=%0d bt=%b exp pc=0 lvl=0 bt=1",
                        ifb.pc, lvl_b, ifb.branch_taken);
    end
    wb_b(32'h103F_0007);
    checks++;
    if (ifb.pc !== 4'h7 || lvl_b !== 2'd1) begin
      fails++; $display("FAIL mid_setup got pc=%h lvl=%0d exp pc=7 lvl=1", ifb.pc, lvl_b);
    end
    ifb.wb_en = 1'b1; ifb.crnt_instrn = 32'h103F_0003;
    @(negedge clk); rst_b_n = 1'b0; #1;
    checks++;
    if (ifb.pc !== 4'h5 || lvl_b !== 2'd0 || ifb.branch_taken !== 1'b0) begin
      fails++; $display("FAIL mid_reset got pc=%h lvl=%0d bt=%b exp pc=5 lvl=0 bt=0",
                        ifb.pc, lvl_b, ifb.branch_taken);
    end
    @(posedge clk); #1;
    ifb.wb_en = 1'b0; ifb.crnt_instrn = 32'h0000_0000;
    checks++;
    if (ifb.pc !== 4'h5 || lvl_b !== 2'd0) begin
      fails++; $display("FAIL mid_reset_hold got pc=%h lvl=%0d exp pc=5 lvl=0", ifb.pc, lvl_b);
    end
    @(negedge clk); rst_b_n = 1'b1;
    wb_b(NOP);
    checks++;
    if (ifb.pc !== 4'h6) begin fails++; $display("FAIL post_reset_seq got=%h exp=6", ifb.pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_cond_jump();
    test_call_return();
    test_overflow();
    test_underflow();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
